load_unit: RTL and testbench
============================

LOAD_UNIT -- requirements
Module: load_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width; legal values 32 or 64.
REQ-002 SHALL have parameter MISALIGNED_EN, default 1; 1 means split boundary-crossing loads into two beats, 0 means fault them.
REQ-003 SHALL have the following ports; clock and reset are listed first:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- req_valid  in  1  load request valid.
- req_ready  out  1  unit can accept a request.
- req_addr  in  XLEN  byte address of the load.
- req_f3  in  3  RISC-V load funct3.
- mem_req_valid  out  1  memory read request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_addr  out  XLEN  word-aligned address (low log2(XLEN/8) bits are zero).
- mem_req_be  out  XLEN/8  byte enables of the bytes used.
- mem_rsp_valid  in  1  read data valid, one-cycle pulse.
- mem_rsp_data  in  XLEN  read data.
- wb_valid  out  1  one-cycle pulse; wb_data is valid.
- wb_data  out  XLEN  aligned, extended load result.
- fault_valid  out  1  one-cycle pulse: misaligned (MISALIGNED_EN=0) or illegal f3.
- fault_illegal  out  1  qualifies fault_valid: 1 means illegal f3, 0 means misaligned.

Function
REQ-004 SHALL decode size = 1<<req_f3[1:0] bytes; unsigned when req_f3[2]=1; sign-extend otherwise.
REQ-005 SHALL treat f3 111, and 011/110 when XLEN=32, as illegal: fault_valid and fault_illegal SHALL pulse 1 cycle after acceptance, and no memory request SHALL be issued.
REQ-006 SHALL compute off = req_addr mod (XLEN/8); a load SHALL be crossing when off+size > XLEN/8.
REQ-007 SHALL run the FSM IDLE -> ISSUE0 -> WAIT0 -> [ISSUE1 -> WAIT1] -> RESP -> IDLE; the bracketed states are taken only for crossing loads with MISALIGNED_EN=1.
REQ-008 SHALL, for a crossing load with MISALIGNED_EN=0, go IDLE -> RESP and assert fault_valid with fault_illegal=0, with no memory access.
REQ-009 SHALL assert req_ready only in IDLE; acceptance is req_valid and req_ready at a clock edge, which latches the address and f3.
REQ-010 SHALL hold mem_req_valid, mem_req_addr and mem_req_be stable in ISSUEx until mem_req_ready; it SHALL then move to WAITx.
REQ-011 SHALL have at most one memory request outstanding.
REQ-012 SHALL issue beat0 at aligned(addr) with be for bytes off..min(off+size, XLEN/8)-1.
REQ-013 SHALL issue beat1 at aligned(addr)+XLEN/8 with be for bytes 0..off+size-XLEN/8-1.
REQ-014 SHALL in WAITx capture mem_rsp_data on mem_rsp_valid, and SHALL ignore mem_rsp_valid in IDLE, ISSUEx and RESP.
REQ-015 SHALL assemble the result as {beat1, beat0} >> (8*off), truncated to size, then extended.
REQ-016 SHALL pulse wb_valid in RESP, exactly 1 cycle after the final mem_rsp_valid; wb_data SHALL hold its value until the next wb_valid.
REQ-017 SHALL return to IDLE after RESP, so back-to-back accepted requests are at least 4 cycles apart (aligned case).

Reset
REQ-018 SHALL, while rst_n=0, immediately force IDLE, with req_ready=0 only while reset is asserted.
REQ-019 SHALL, during reset, force mem_req_valid=0, wb_valid=0, fault_valid=0, fault_illegal=0, wb_data=0, mem_req_addr=0 and mem_req_be=0.
REQ-020 SHALL abandon an in-flight load on reset mid-operation with no wb_valid; a late mem_rsp_valid arriving afterwards SHALL be discarded (IDLE).
REQ-021 SHALL assert req_ready=1 in the first cycle after rst_n rises.

Structure
REQ-022 SHALL place the f3 encodings (LB..LWU), the FSM state enum, and a size-decode function in a shared package, load_unit_pkg.
REQ-023 SHALL use one sub-module, load_extract: a combinational 2*XLEN shift, truncate and extend stage, parametrised by XLEN.

Verification
REQ-024 SHALL verify LB, XLEN=32: addr 0x1003, rsp 0x80000000 -> be 4'b1000, wb_data 0xFFFFFF80.
REQ-025 SHALL verify LHU: addr 0x2, rsp 0xBEEF0000 -> be 4'b1100, wb_data 0x0000BEEF.
REQ-026 SHALL verify a misaligned LW, MISALIGNED_EN=1: addr 0x6; beat0 at 0x4, be 4'b1100, rsp 0xDDCC0000; beat1 at 0x8, be 4'b0011, rsp 0x0000BBAA -> wb_data 0xBBAADDCC.
REQ-027 SHALL verify faults: MISALIGNED_EN=0, LH at 0x3 -> fault_valid with fault_illegal=0, no mem_req_valid; f3=111 -> fault_illegal=1.
REQ-028 SHALL verify backpressure: mem_req_ready low for 3 cycles -> mem_req_valid, mem_req_addr and mem_req_be stable, and exactly one handshake.
REQ-029 SHALL verify reset in WAIT1: then mem_rsp_valid -> no wb_valid, then req_ready=1 and a fresh LW at 0x0 completes correctly; XLEN=64 LD at 0xC -> two beats, correct 64-bit result.

Source files
------------

// File: rtl/load_unit_pkg.sv
// load_unit_pkg
//   Shared definitions for the load unit: RISC-V load funct3 encodings,
//   FSM state and fault-kind enums, and the size/legality decode helpers.
//   No ports; imported by load_unit.

package load_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE0 = 3'd1,
        ST_WAIT0  = 3'd2,
        ST_ISSUE1 = 3'd3,
        ST_WAIT1  = 3'd4,
        ST_RESP   = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        FLT_NONE     = 2'd0,
        FLT_MISALIGN = 2'd1,
        FLT_ILLEGAL  = 2'd2
    } fault_e;

    // Access size in bytes: 1, 2, 4 or 8.
    function automatic logic [3:0] size_bytes(input logic [2:0] f3);
        return 4'd1 << f3[1:0];
    endfunction

    // 111 is never a load; LD and LWU only exist on a 64-bit datapath.
    function automatic logic f3_illegal(input logic [2:0] f3, input logic is_rv32);
        return (f3 == 3'b111) || (is_rv32 && ((f3 == F3_LD) || (f3 == F3_LWU)));
    endfunction

endpackage

// File: rtl/load_unit_extract.sv
// load_extract
//   Combinational result formatter. Joins the two memory beats into a
//   2*XLEN window, shifts it down by the byte offset, keeps the low
//   1/2/4/8 bytes and sign- or zero-extends them to XLEN.
//   Ports:
//     beat0_i  in  XLEN   first (lower-address) memory word
//     beat1_i  in  XLEN   second word, zero when the load does not cross
//     off_i    in  OFFW   byte offset of the load inside beat0
//     f3_i     in  3      load funct3 (size in [1:0], unsigned in [2])
//     data_o   out XLEN   aligned, extended load result

module load_extract #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0]              beat0_i,
    input  logic [XLEN-1:0]              beat1_i,
    input  logic [$clog2(XLEN/8)-1:0]    off_i,
    input  logic [2:0]                   f3_i,
    output logic [XLEN-1:0]              data_o
);

    localparam logic [XLEN-1:0] ONE = {{(XLEN-1){1'b0}}, 1'b1};

    logic [XLEN-1:0] low;
    logic [XLEN-1:0] mask;
    logic [XLEN-1:0] msb;
    logic [6:0]      nbits;
    logic            sign;

    always_comb begin
        low   = XLEN'({beat1_i, beat0_i} >> {off_i, 3'b000});
        nbits = 7'd8 << f3_i[1:0];
        // A shift of the full width yields zero, so the all-ones mask for a
        // full-width access falls out of the subtraction without a special case.
        mask  = (ONE << nbits) - ONE;
        msb   = mask & ~(mask >> 1);
        sign  = ~f3_i[2] & (|(low & msb));
        data_o = (low & mask) | (sign ? ~mask : '0);
    end

endmodule

// File: rtl/load_unit.sv
// load_unit
//   Single-outstanding load unit. Accepts one load at a time, issues one
//   aligned memory read (two when the access crosses a word boundary and
//   MISALIGNED_EN=1), then formats and returns the result or a fault.
//   Ports:
//     clk, rst_n                      clock, async active-low reset
//     req_valid/req_ready             load request handshake
//     req_addr, req_f3                byte address and funct3 of the load
//     mem_req_valid/mem_req_ready     memory read request handshake
//     mem_req_addr, mem_req_be        word-aligned address and byte enables
//     mem_rsp_valid, mem_rsp_data     read data return (single-cycle pulse)
//     wb_valid, wb_data               result pulse and held result
//     fault_valid, fault_illegal      fault pulse; 1 = illegal f3, 0 = misaligned
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | ready for a new load
// ST_ISSUE0 | first beat request presented, waiting for mem_req_ready
// ST_WAIT0  | waiting for first beat data
// ST_ISSUE1 | second beat request presented (crossing loads only)
// ST_WAIT1  | waiting for second beat data
// ST_RESP   | one-cycle wb_valid or fault_valid pulse

module load_unit
    import load_unit_pkg::*;
#(
    parameter int unsigned XLEN          = 32,
    parameter bit          MISALIGNED_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [XLEN-1:0]      req_addr,
    input  logic [2:0]           req_f3,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic [XLEN-1:0]      mem_req_addr,
    output logic [XLEN/8-1:0]    mem_req_be,
    input  logic                 mem_rsp_valid,
    input  logic [XLEN-1:0]      mem_rsp_data,
    output logic                 wb_valid,
    output logic [XLEN-1:0]      wb_data,
    output logic                 fault_valid,
    output logic                 fault_illegal
);

    localparam int unsigned NB   = XLEN / 8;
    localparam int unsigned OFFW = $clog2(NB);
    localparam int unsigned BEW  = 2 * NB;

    state_e            state_q,   state_d;
    fault_e            fault_q,   fault_d;
    logic [XLEN-1:0]   addr_q,    addr_d;
    logic [2:0]        f3_q,      f3_d;
    logic              cross_q,   cross_d;
    logic [XLEN-1:0]   beat0_q,   beat0_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;

    logic [OFFW-1:0]   req_off;
    logic [4:0]        req_end;
    logic              req_cross;
    logic              req_bad_f3;

    logic [OFFW-1:0]   off_q;
    logic [XLEN-1:0]   addr_base;
    logic [XLEN-1:0]   addr_next;
    logic [BEW-1:0]    be_span;

    logic [XLEN-1:0]   ext_beat0;
    logic [XLEN-1:0]   ext_beat1;
    logic [XLEN-1:0]   ext_data;

    // Request decode, evaluated against the incoming request in IDLE.
    always_comb begin
        req_off    = req_addr[OFFW-1:0];
        req_end    = 5'(req_off) + 5'(size_bytes(req_f3));
        req_cross  = req_end > 5'(NB);
        req_bad_f3 = f3_illegal(req_f3, XLEN == 32);
    end

    // Beat addresses and byte enables for the latched load. be_span covers
    // both words; the low half belongs to beat0, the high half to beat1.
    always_comb begin
        off_q     = addr_q[OFFW-1:0];
        addr_base = {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}};
        addr_next = addr_base + XLEN'(NB);
        be_span   = (BEW'(1) << size_bytes(f3_q)) - BEW'(1);
        be_span   = be_span << off_q;
    end

    // The final beat is fed straight from the bus so the result is ready to
    // register on the same edge that moves the FSM into RESP.
    always_comb begin
        ext_beat0 = (state_q == ST_WAIT0) ? mem_rsp_data : beat0_q;
        ext_beat1 = (state_q == ST_WAIT1) ? mem_rsp_data : '0;
    end

    load_extract #(
        .XLEN (XLEN)
    ) u_extract (
        .beat0_i (ext_beat0),
        .beat1_i (ext_beat1),
        .off_i   (off_q),
        .f3_i    (f3_q),
        .data_o  (ext_data)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            fault_q   <= FLT_NONE;
            addr_q    <= '0;
            f3_q      <= '0;
            cross_q   <= 1'b0;
            beat0_q   <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            fault_q   <= fault_d;
            addr_q    <= addr_d;
            f3_q      <= f3_d;
            cross_q   <= cross_d;
            beat0_q   <= beat0_d;
            wb_data_q <= wb_data_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        fault_d   = fault_q;
        addr_d    = addr_q;
        f3_d      = f3_q;
        cross_d   = cross_q;
        beat0_d   = beat0_q;
        wb_data_d = wb_data_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    f3_d    = req_f3;
                    cross_d = req_cross;
                    if (req_bad_f3) begin
                        fault_d = FLT_ILLEGAL;
                        state_d = ST_RESP;
                    end else if (req_cross && !MISALIGNED_EN) begin
                        fault_d = FLT_MISALIGN;
                        state_d = ST_RESP;
                    end else begin
                        fault_d = FLT_NONE;
                        state_d = ST_ISSUE0;
                    end
                end
            end
            ST_ISSUE0: begin
                if (mem_req_ready) begin
                    state_d = ST_WAIT0;
                end
            end
            ST_WAIT0: begin
                if (mem_rsp_valid) begin
                    beat0_d = mem_rsp_data;
                    if (cross_q && MISALIGNED_EN) begin
                        state_d = ST_ISSUE1;
                    end else begin
                        wb_data_d = ext_data;
                        state_d   = ST_RESP;
                    end
                end
            end
            ST_ISSUE1: begin
                if (mem_req_ready) begin
                    state_d = ST_WAIT1;
                end
            end
            ST_WAIT1: begin
                if (mem_rsp_valid) begin
                    wb_data_d = ext_data;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs. req_ready is gated by rst_n so it reads low for the whole
    // time reset is held, even though the state register already sits in IDLE.
    always_comb begin
        req_ready     = (state_q == ST_IDLE) && rst_n;
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        mem_req_be    = '0;
        wb_valid      = 1'b0;
        fault_valid   = 1'b0;
        fault_illegal = 1'b0;

        case (state_q)
            ST_ISSUE0: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = addr_base;
                mem_req_be    = be_span[NB-1:0];
            end
            ST_ISSUE1: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = addr_next;
                mem_req_be    = be_span[BEW-1:NB];
            end
            ST_RESP: begin
                if (fault_q == FLT_NONE) begin
                    wb_valid = 1'b1;
                end else begin
                    fault_valid   = 1'b1;
                    fault_illegal = (fault_q == FLT_ILLEGAL);
                end
            end
            default: begin
            end
        endcase
    end

    assign wb_data = wb_data_q;

endmodule

// File: tb/tb_load_unit.sv
module tb_load_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Instance A: XLEN=32, misaligned loads split
    logic        a_req_valid, a_req_ready, a_mem_req_valid, a_mem_req_ready;
    logic [31:0] a_req_addr, a_mem_req_addr, a_mem_rsp_data, a_wb_data;
    logic [2:0]  a_req_f3;
    logic [3:0]  a_mem_req_be;
    logic        a_mem_rsp_valid, a_wb_valid, a_fault_valid, a_fault_illegal;

    // Instance B: XLEN=32, misaligned loads fault
    logic        b_req_valid, b_req_ready, b_mem_req_valid, b_mem_req_ready;
    logic [31:0] b_req_addr, b_mem_req_addr, b_mem_rsp_data, b_wb_data;
    logic [2:0]  b_req_f3;
    logic [3:0]  b_mem_req_be;
    logic        b_mem_rsp_valid, b_wb_valid, b_fault_valid, b_fault_illegal;

    // Instance C: XLEN=64, misaligned loads split
    logic        c_req_valid, c_req_ready, c_mem_req_valid, c_mem_req_ready;
    logic [63:0] c_req_addr, c_mem_req_addr, c_mem_rsp_data, c_wb_data;
    logic [2:0]  c_req_f3;
    logic [7:0]  c_mem_req_be;
    logic        c_mem_rsp_valid, c_wb_valid, c_fault_valid, c_fault_illegal;

    load_unit #(.XLEN(32), .MISALIGNED_EN(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_addr(a_req_addr), .req_f3(a_req_f3),
        .mem_req_valid(a_mem_req_valid), .mem_req_ready(a_mem_req_ready),
        .mem_req_addr(a_mem_req_addr), .mem_req_be(a_mem_req_be),
        .mem_rsp_valid(a_mem_rsp_valid), .mem_rsp_data(a_mem_rsp_data),
        .wb_valid(a_wb_valid), .wb_data(a_wb_data),
        .fault_valid(a_fault_valid), .fault_illegal(a_fault_illegal)
    );

    load_unit #(.XLEN(32), .MISALIGNED_EN(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_addr(b_req_addr), .req_f3(b_req_f3),
        .mem_req_valid(b_mem_req_valid), .mem_req_ready(b_mem_req_ready),
        .mem_req_addr(b_mem_req_addr), .mem_req_be(b_mem_req_be),
        .mem_rsp_valid(b_mem_rsp_valid), .mem_rsp_data(b_mem_rsp_data),
        .wb_valid(b_wb_valid), .wb_data(b_wb_data),
        .fault_valid(b_fault_valid), .fault_illegal(b_fault_illegal)
    );

    load_unit #(.XLEN(64), .MISALIGNED_EN(1'b1)) u_c (
        .clk(clk), .rst_n(rst_n),
        .req_valid(c_req_valid), .req_ready(c_req_ready),
        .req_addr(c_req_addr), .req_f3(c_req_f3),
        .mem_req_valid(c_mem_req_valid), .mem_req_ready(c_mem_req_ready),
        .mem_req_addr(c_mem_req_addr), .mem_req_be(c_mem_req_be),
        .mem_rsp_valid(c_mem_rsp_valid), .mem_rsp_data(c_mem_rsp_data),
        .wb_valid(c_wb_valid), .wb_data(c_wb_data),
        .fault_valid(c_fault_valid), .fault_illegal(c_fault_illegal)
    );

    int a_hs = 0;
    int b_mreq = 0;
    always @(posedge clk) begin
        if (a_mem_req_valid && a_mem_req_ready) a_hs <= a_hs + 1;
        if (b_mem_req_valid) b_mreq <= b_mreq + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic a_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] ea0, input logic [3:0] eb0, input logic [31:0] d0,
                          input bit two, input logic [31:0] ea1, input logic [3:0] eb1,
                          input logic [31:0] d1, input logic [31:0] ewb);
        check({tag, "_ready"}, a_req_ready, 1);
        a_req_valid = 1'b1; a_req_addr = addr; a_req_f3 = f3;
        tick();
        a_req_valid = 1'b0; a_req_addr = 32'hFFFF_FFFF; a_req_f3 = 3'b111;
        check({tag, "_busy"}, a_req_ready, 0);
        check({tag, "_v0"}, a_mem_req_valid, 1);
        check({tag, "_addr0"}, a_mem_req_addr, ea0);
        check({tag, "_be0"}, a_mem_req_be, eb0);
        a_mem_req_ready = 1'b1;
        tick();
        a_mem_req_ready = 1'b0;
        check({tag, "_wait0"}, a_mem_req_valid, 0);
        a_mem_rsp_valid = 1'b1; a_mem_rsp_data = d0;
        tick();
        a_mem_rsp_valid = 1'b0;
        if (two) begin
            check({tag, "_nowb"}, a_wb_valid, 0);
            check({tag, "_v1"}, a_mem_req_valid, 1);
            check({tag, "_addr1"}, a_mem_req_addr, ea1);
            check({tag, "_be1"}, a_mem_req_be, eb1);
            a_mem_req_ready = 1'b1;
            tick();
            a_mem_req_ready = 1'b0;
            a_mem_rsp_valid = 1'b1; a_mem_rsp_data = d1;
            tick();
            a_mem_rsp_valid = 1'b0;
        end
        check({tag, "_wbv"}, a_wb_valid, 1);
        check({tag, "_wbd"}, a_wb_data, ewb);
        check({tag, "_nofault"}, a_fault_valid, 0);
        tick();
        check({tag, "_wbpulse"}, a_wb_valid, 0);
        check({tag, "_wbhold"}, a_wb_data, ewb);
    endtask

    task automatic c_load(input string tag, input logic [63:0] addr, input logic [2:0] f3,
                          input logic [63:0] ea0, input logic [7:0] eb0, input logic [63:0] d0,
                          input bit two, input logic [63:0] ea1, input logic [7:0] eb1,
                          input logic [63:0] d1, input logic [63:0] ewb);
        check({tag, "_ready"}, c_req_ready, 1);
        c_req_valid = 1'b1; c_req_addr = addr; c_req_f3 = f3;
        tick();
        c_req_valid = 1'b0; c_req_addr = '1;
        check({tag, "_v0"}, c_mem_req_valid, 1);
        check({tag, "_addr0"}, c_mem_req_addr, ea0);
        check({tag, "_be0"}, c_mem_req_be, eb0);
        c_mem_req_ready = 1'b1;
        tick();
        c_mem_req_ready = 1'b0;
        c_mem_rsp_valid = 1'b1; c_mem_rsp_data = d0;
        tick();
        c_mem_rsp_valid = 1'b0;
        if (two) begin
            check({tag, "_v1"}, c_mem_req_valid, 1);
            check({tag, "_addr1"}, c_mem_req_addr, ea1);
            check({tag, "_be1"}, c_mem_req_be, eb1);
            c_mem_req_ready = 1'b1;
            tick();
            c_mem_req_ready = 1'b0;
            c_mem_rsp_valid = 1'b1; c_mem_rsp_data = d1;
            tick();
            c_mem_rsp_valid = 1'b0;
        end
        check({tag, "_wbv"}, c_wb_valid, 1);
        check({tag, "_wbd"}, c_wb_data, ewb);
        check({tag, "_nofault"}, {c_fault_valid, c_fault_illegal}, 0);
        tick();
        check({tag, "_wbpulse"}, c_wb_valid, 0);
    endtask

    initial begin
        a_req_valid = 0; a_req_addr = 0; a_req_f3 = 0; a_mem_req_ready = 0;
        a_mem_rsp_valid = 0; a_mem_rsp_data = 0;
        b_req_valid = 0; b_req_addr = 0; b_req_f3 = 0; b_mem_req_ready = 0;
        b_mem_rsp_valid = 0; b_mem_rsp_data = 0;
        c_req_valid = 0; c_req_addr = 0; c_req_f3 = 0; c_mem_req_ready = 0;
        c_mem_rsp_valid = 0; c_mem_rsp_data = 0;

        // Reset values
        tick();
        tick();
        check("rst_ready", a_req_ready, 0);
        check("rst_mreq", a_mem_req_valid, 0);
        check("rst_maddr", a_mem_req_addr, 0);
        check("rst_mbe", a_mem_req_be, 0);
        check("rst_wbv", a_wb_valid, 0);
        check("rst_wbd", a_wb_data, 0);
        check("rst_fault", {a_fault_valid, a_fault_illegal}, 0);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", a_req_ready, 1);

        // Single-beat loads
        a_load("lb", 32'h1003, 3'b000, 32'h1000, 4'b1000, 32'h8000_0000, 0, 0, 0, 0, 32'hFFFF_FF80);
        a_load("lhu", 32'h2, 3'b101, 32'h0, 4'b1100, 32'hBEEF_0000, 0, 0, 0, 0, 32'h0000_BEEF);
        a_load("lh_mid", 32'h1, 3'b001, 32'h0, 4'b0110, 32'h00F1_2300, 0, 0, 0, 0, 32'hFFFF_F123);
        a_load("lbu", 32'h3, 3'b100, 32'h0, 4'b1000, 32'h8000_0000, 0, 0, 0, 0, 32'h0000_0080);

        // Boundary-crossing loads
        a_load("lw_split", 32'h6, 3'b010, 32'h4, 4'b1100, 32'hDDCC_0000, 1, 32'h8, 4'b0011,
               32'h0000_BBAA, 32'hBBAA_DDCC);
        a_load("lh_split", 32'h3, 3'b001, 32'h0, 4'b1000, 32'hAB00_0000, 1, 32'h4, 4'b0001,
               32'h0000_00CD, 32'hFFFF_CDAB);

        // Stray response in IDLE is ignored
        a_mem_rsp_valid = 1'b1; a_mem_rsp_data = 32'hDEAD_BEEF;
        tick();
        a_mem_rsp_valid = 1'b0;
        check("idle_rsp_wbv", a_wb_valid, 0);
        check("idle_rsp_wbd", a_wb_data, 32'hFFFF_CDAB);
        check("idle_rsp_ready", a_req_ready, 1);

        // Backpressure: ready low for 3 cycles, stray response while issuing
        begin
            int hs0;
            hs0 = a_hs;
            a_req_valid = 1'b1; a_req_addr = 32'h10; a_req_f3 = 3'b010;
            tick();
            a_req_valid = 1'b0;
            a_mem_rsp_valid = 1'b1; a_mem_rsp_data = 32'h1111_1111;
            for (int i = 0; i < 3; i++) begin
                check("bp_valid", a_mem_req_valid, 1);
                check("bp_addr", a_mem_req_addr, 32'h10);
                check("bp_be", a_mem_req_be, 4'b1111);
                tick();
                a_mem_rsp_valid = 1'b0;
            end
            check("bp_still", a_mem_req_valid, 1);
            check("bp_nohs", a_hs - hs0, 0);
            a_mem_req_ready = 1'b1;
            tick();
            a_mem_req_ready = 1'b0;
            check("bp_wait", a_mem_req_valid, 0);
            check("bp_onehs", a_hs - hs0, 1);
            a_mem_rsp_valid = 1'b1; a_mem_rsp_data = 32'h1234_5678;
            tick();
            a_mem_rsp_valid = 1'b0;
            check("bp_wbv", a_wb_valid, 1);
            check("bp_wbd", a_wb_data, 32'h1234_5678);
            tick();
            check("bp_hs_total", a_hs - hs0, 1);
        end

        // Illegal funct3
        a_req_valid = 1'b1; a_req_addr = 32'h0; a_req_f3 = 3'b111;
        tick();
        a_req_valid = 1'b0;
        check("ill111_fv", a_fault_valid, 1);
        check("ill111_fi", a_fault_illegal, 1);
        check("ill111_mreq", a_mem_req_valid, 0);
        check("ill111_wbv", a_wb_valid, 0);
        tick();
        check("ill111_pulse", a_fault_valid, 0);
        check("ill111_ready", a_req_ready, 1);
        check("ill111_wbhold", a_wb_data, 32'h1234_5678);
        a_req_valid = 1'b1; a_req_addr = 32'h8; a_req_f3 = 3'b011;
        tick();
        a_req_valid = 1'b0;
        check("ill011_fv", a_fault_valid, 1);
        check("ill011_fi", a_fault_illegal, 1);
        check("ill011_mreq", a_mem_req_valid, 0);
        tick();

        // Reset while waiting for the second beat
        a_req_valid = 1'b1; a_req_addr = 32'h6; a_req_f3 = 3'b010;
        tick();
        a_req_valid = 1'b0;
        a_mem_req_ready = 1'b1;
        tick();
        a_mem_req_ready = 1'b0;
        a_mem_rsp_valid = 1'b1; a_mem_rsp_data = 32'h5566_0000;
        tick();
        a_mem_rsp_valid = 1'b0;
        check("w1_issue1", a_mem_req_addr, 32'h8);
        a_mem_req_ready = 1'b1;
        tick();
        a_mem_req_ready = 1'b0;
        check("w1_in_wait", a_mem_req_valid, 0);
        rst_n = 1'b0;
        #1;
        check("w1_rst_ready", a_req_ready, 0);
        check("w1_rst_wbd", a_wb_data, 0);
        tick();
        rst_n = 1'b1;
        #1;
        check("w1_rel_ready", a_req_ready, 1);
        a_mem_rsp_valid = 1'b1; a_mem_rsp_data = 32'h0000_7788;
        tick();
        a_mem_rsp_valid = 1'b0;
        check("w1_late_wbv", a_wb_valid, 0);
        check("w1_late_mreq", a_mem_req_valid, 0);
        a_load("lw_fresh", 32'h0, 3'b010, 32'h0, 4'b1111, 32'hCAFE_F00D, 0, 0, 0, 0, 32'hCAFE_F00D);

        // MISALIGNED_EN=0: crossing LH faults, aligned LH goes to memory
        b_req_valid = 1'b1; b_req_addr = 32'h3; b_req_f3 = 3'b001;
        tick();
        b_req_valid = 1'b0;
        check("mis_fv", b_fault_valid, 1);
        check("mis_fi", b_fault_illegal, 0);
        check("mis_mreq", b_mem_req_valid, 0);
        check("mis_wbv", b_wb_valid, 0);
        tick();
        check("mis_pulse", b_fault_valid, 0);
        check("mis_ready", b_req_ready, 1);
        check("mis_no_mem", b_mreq, 0);
        b_req_valid = 1'b1; b_req_addr = 32'h2; b_req_f3 = 3'b001;
        tick();
        b_req_valid = 1'b0;
        check("b_lh_v", b_mem_req_valid, 1);
        check("b_lh_addr", b_mem_req_addr, 32'h0);
        check("b_lh_be", b_mem_req_be, 4'b1100);
        b_mem_req_ready = 1'b1;
        tick();
        b_mem_req_ready = 1'b0;
        b_mem_rsp_valid = 1'b1; b_mem_rsp_data = 32'h7FFF_0000;
        tick();
        b_mem_rsp_valid = 1'b0;
        check("b_lh_wbv", b_wb_valid, 1);
        check("b_lh_wbd", b_wb_data, 32'h0000_7FFF);
        tick();

        // XLEN=64
        c_load("ld_split", 64'hC, 3'b011, 64'h8, 8'hF0, 64'h4433_2211_0000_0000, 1, 64'h10, 8'h0F,
               64'h0000_0000_8877_6655, 64'h8877_6655_4433_2211);
        c_load("lw64", 64'h4, 3'b010, 64'h0, 8'hF0, 64'h8000_0000_0000_0000, 0, 0, 0, 0,
               64'hFFFF_FFFF_8000_0000);
        c_load("lwu64", 64'hC, 3'b110, 64'h8, 8'hF0, 64'hDEAD_BEEF_0000_0000, 0, 0, 0, 0,
               64'h0000_0000_DEAD_BEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
